// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit subtractor computing (a - b - bin), LSB
//                first, one full-subtractor evaluation per clock against a
//                registered borrow. Start/done handshake; results are held
//                until the next operation completes.
//  Ports       : clk, rst (sync, active-high)
//                start, a[WIDTH], b[WIDTH], bin  -- request and operands
//                busy, done, diff[WIDTH], bout   -- status and result
//                ovf                             -- signed overflow (optional)
//  Options     : define SERIAL_SUB_OVF_EN to add the ovf port and flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               bout_q,   bout_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_q,    ovf_d;
`endif

    // Full-subtractor cell on the current LSBs and the registered borrow
    logic w_x, w_y, w_d_bit, w_br_next;

    always_comb begin
        w_x       = a_sr_q[0];
        w_y       = b_sr_q[0];
        w_d_bit   = w_x ^ w_y ^ borrow_q;
        w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & borrow_q);
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                end
            end
            ST_SHIFT: begin
                res_d    = {w_d_bit, res_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = w_br_next;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    // Publish the completed result directly, including the
                    // bit being produced this cycle.
                    diff_d  = {w_d_bit, res_q[WIDTH-1:1]};
                    bout_d  = w_br_next;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // borrow_q here is the borrow into the MSB cell
                    ovf_d   = borrow_q ^ w_br_next;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Directed self-checking bench for serial_subtractor (WIDTH=8)
//                with a queue scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp;
    int           n_fail;
    int           done_seen;
    logic [W-1:0] last_diff;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: plain integer arithmetic
    task automatic push_exp(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        exp_t         e;
        logic [W:0]   r;
        int           s;
        int           sa;
        int           sb;
        r    = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
        sa   = $signed(ia);
        sb   = $signed(ib);
        s    = sa - sb - (ibin ? 1 : 0);
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (s < -128) || (s > 127);
        exp_q.push_back(e);
    endtask

    // Advance one clock, sample 1 time unit after the edge, score any done
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            done_seen++;
            chk("done_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("diff", 64'(diff), 64'(e.d));
                chk("bout", 64'(bout), 64'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", 64'(ovf), 64'(e.ov));
`endif
                last_diff = e.d;
            end
        end
    endtask

    // One operation with start pulsed for a single cycle, full timing checks
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        push_exp(ia, ib, ibin);
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
        chk("busy_after_accept", 64'(busy), 64'd1);
        for (int k = 1; k <= W; k++) begin
            tick();
            chk("busy_during_op", 64'(busy), 64'd1);
            if (k < W) begin
                chk("done_early", 64'(done), 64'd0);
                chk("diff_held", 64'(diff), 64'(last_diff));
            end else begin
                chk("done_latency", 64'(done), 64'd1);
            end
        end
        tick();
        chk("done_pulse_end", 64'(done), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_done_before;
        n_cmp = 0; n_fail = 0; done_seen = 0; last_diff = '0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif

        // Basic, underflow, signed overflow, borrow-in
        run_op(8'h5A, 8'h13, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'h7F, 8'h80, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1);

        // Start ignored while busy
        n_done_before = done_seen;
        a = 8'h5A; b = 8'h13; bin = 1'b0; start = 1'b1;
        push_exp(8'h5A, 8'h13, 1'b0);
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hFF; b = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2 * W; k++) tick();
        chk("ignored_start_done_count", 64'(done_seen - n_done_before), 64'd1);
        chk("ignored_start_diff", 64'(diff), 64'h47);
        chk("ignored_start_idle", 64'(busy), 64'd0);

        // Start held high: second acceptance W+2 edges after the first
        a = 8'h5A; b = 8'h13; bin = 1'b0; start = 1'b1;
        push_exp(8'h5A, 8'h13, 1'b0);
        tick();
        for (int n = 1; n <= W + 2; n++) begin
            tick();
            if (n == W + 1) begin
                chk("held_gap_idle", 64'(busy), 64'd0);
                push_exp(8'h5A, 8'h13, 1'b0);
            end else begin
                chk("held_busy", 64'(busy), 64'd1);
            end
        end
        start = 1'b0;
        for (int k = 0; k < W + 2; k++) tick();
        chk("held_queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation, at the 4th SHIFT cycle
        n_done_before = done_seen;
        a = 8'hC3; b = 8'h11; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        last_diff = '0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_bout", 64'(bout), 64'd0);
        for (int k = 0; k < W + 2; k++) tick();
        chk("abort_no_done", 64'(done_seen - n_done_before), 64'd0);
        run_op(8'h20, 8'h01, 1'b0);
        chk("after_abort_diff", 64'(diff), 64'h1F);

        // A few pseudo-random operations
        for (int k = 0; k < 6; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
